// File: rtl/render_scheduler_pkg.sv
// Shared types and defaults for the per-frame render sequencer.
package render_scheduler_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT_RD,
        ISSUE,
        GAP,
        DRAIN,
        DONE
    } state_t;

    // One particle BRAM word: {f_x, f_y, f_z}, x in the top 16 bits.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } particle_t;

    localparam int unsigned DEFAULT_WIDTH    = 320;
    localparam int unsigned DEFAULT_HEIGHT   = 180;
    localparam logic [15:0] DEFAULT_BG_COLOR = 16'h0000;

    // Number of framebuffer pixels the clear engine must cover.
    function automatic int unsigned fb_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/render_scheduler_fb_write_arbiter.sv
// Fixed-priority 2:1 framebuffer write mux: render pixels always win,
// the clear engine only writes (and advances) when granted.
module fb_write_arbiter (
    input  logic        render_req_i,
    input  logic [15:0] render_addr_i,
    input  logic [15:0] render_data_i,
    input  logic        clear_req_i,
    input  logic [15:0] clear_addr_i,
    input  logic [15:0] clear_data_i,
    output logic        clear_gnt_o,
    output logic        fb_we_o,
    output logic [15:0] fb_addr_o,
    output logic [15:0] fb_data_o
);

    // Select the write source for this cycle; render is never dropped.
    always_comb begin
        clear_gnt_o = 1'b0;
        fb_we_o     = 1'b0;
        fb_addr_o   = '0;
        fb_data_o   = '0;
        if (render_req_i) begin
            fb_we_o   = 1'b1;
            fb_addr_o = render_addr_i;
            fb_data_o = render_data_i;
        end else if (clear_req_i) begin
            clear_gnt_o = 1'b1;
            fb_we_o     = 1'b1;
            fb_addr_o   = clear_addr_i;
            fb_data_o   = clear_data_i;
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// Per-frame sequencer: clear the framebuffer, stream particles from BRAM
// into the renderer over valid/ready, wait for the pipeline to go quiet,
// then pulse frame_done. Also owns the single framebuffer write port.
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT       = DEFAULT_HEIGHT,
    parameter int unsigned PMEM_LATENCY = 2,
    parameter int unsigned ISSUE_GAP    = 2,
    parameter int unsigned DRAIN_CYCLES = 64,
    parameter logic [15:0] BG_COLOR     = DEFAULT_BG_COLOR
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic [15:0] particle_count_in,
    output logic [15:0] pmem_addr_out,
    input  logic [47:0] pmem_data_in,
    output logic [15:0] render_x_out,
    output logic [15:0] render_y_out,
    output logic [15:0] render_z_out,
    output logic        render_valid_out,
    input  logic        render_ready_in,
    input  logic        render_pixel_valid_in,
    input  logic [15:0] render_addr_in,
    input  logic [15:0] render_color_in,
    output logic        fb_we_out,
    output logic [15:0] fb_addr_out,
    output logic [15:0] fb_data_out,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam int unsigned FB_PIXELS  = fb_pixels(WIDTH, HEIGHT);
    // A zero gap would skip the GAP state's own cycle; treat it as one.
    localparam int unsigned GAP_CYCLES = (ISSUE_GAP < 1) ? 1 : ISSUE_GAP;
    localparam logic [15:0] LAST_CLR   = 16'(FB_PIXELS - 1);
    localparam logic [15:0] RD_LAST    = 16'(PMEM_LATENCY);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] clr_addr_q, clr_addr_d;
    // Shared cycle counter: read latency in WAIT_RD, gap in GAP, quiet run in DRAIN.
    logic [15:0] timer_q, timer_d;
    logic [15:0] pmem_addr_q, pmem_addr_d;
    particle_t   pos_q, pos_d;
    logic        valid_q, valid_d;

    particle_t   rd_word;
    logic        clear_req;
    logic        clear_gnt;

    assign rd_word   = pmem_data_in;
    assign clear_req = (state_q == CLEAR);

    fb_write_arbiter u_fb_arb (
        .render_req_i  (render_pixel_valid_in),
        .render_addr_i (render_addr_in),
        .render_data_i (render_color_in),
        .clear_req_i   (clear_req),
        .clear_addr_i  (clr_addr_q),
        .clear_data_i  (BG_COLOR),
        .clear_gnt_o   (clear_gnt),
        .fb_we_o       (fb_we_out),
        .fb_addr_o     (fb_addr_out),
        .fb_data_o     (fb_data_out)
    );

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        clr_addr_d  = clr_addr_q;
        timer_d     = timer_q;
        pmem_addr_d = pmem_addr_q;
        pos_d       = pos_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    count_d    = particle_count_in;
                    clr_addr_d = '0;
                    idx_d      = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                // Address only advances on cycles the arbiter gave to the clear engine.
                if (clear_gnt) begin
                    if (clr_addr_q == LAST_CLR) begin
                        timer_d = '0;
                        state_d = (count_q != '0) ? FETCH : DRAIN;
                    end else begin
                        clr_addr_d = clr_addr_q + 16'd1;
                    end
                end
            end
            FETCH: begin
                pmem_addr_d = idx_q;
                timer_d     = '0;
                state_d     = WAIT_RD;
            end
            WAIT_RD: begin
                // Address became visible on entry, so data lands PMEM_LATENCY cycles later.
                if (timer_q == RD_LAST) begin
                    pos_d   = rd_word;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ISSUE: begin
                if (valid_q && render_ready_in) begin
                    valid_d = 1'b0;
                    idx_d   = idx_q + 16'd1;
                    timer_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // Ready is ignored here: the renderer's ready may still read high from the last transfer.
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = (idx_q == count_q) ? DRAIN : FETCH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DRAIN: begin
                if (!render_pixel_valid_in && render_ready_in) begin
                    if (timer_q == DRAIN_LAST) begin
                        state_d = DONE;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            clr_addr_q  <= '0;
            timer_q     <= '0;
            pmem_addr_q <= '0;
            pos_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            clr_addr_q  <= clr_addr_d;
            timer_q     <= timer_d;
            pmem_addr_q <= pmem_addr_d;
            pos_q       <= pos_d;
            valid_q     <= valid_d;
        end
    end

    assign pmem_addr_out    = pmem_addr_q;
    assign render_x_out     = pos_q.x;
    assign render_y_out     = pos_q.y;
    assign render_z_out     = pos_q.z;
    assign render_valid_out = valid_q;
    assign busy_out         = (state_q != IDLE);
    assign frame_done_out   = (state_q == DONE);

endmodule

// File: tb/tb_render_scheduler.sv
// Randomized bench for render_scheduler with a transaction-level reference:
// expected clear sequence, particle words, transfer count, gap, hold and drain rules.
module tb_render_scheduler;

    localparam int          W    = 16;
    localparam int          H    = 8;
    localparam int          LAT  = 2;
    localparam int          GAPC = 2;
    localparam int          DRN  = 20;
    localparam logic [15:0] BG   = 16'h1234;
    localparam int          NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic [15:0] particle_count_in;
    logic [15:0] pmem_addr_out;
    logic [47:0] pmem_data_in;
    logic [15:0] render_x_out, render_y_out, render_z_out;
    logic        render_valid_out;
    logic        render_ready_in;
    logic        render_pixel_valid_in;
    logic [15:0] render_addr_in;
    logic [15:0] render_color_in;
    logic        fb_we_out;
    logic [15:0] fb_addr_out, fb_data_out;
    logic        busy_out, frame_done_out;

    render_scheduler #(
        .WIDTH(W), .HEIGHT(H), .PMEM_LATENCY(LAT), .ISSUE_GAP(GAPC),
        .DRAIN_CYCLES(DRN), .BG_COLOR(BG)
    ) dut (
        .clk_in               (clk),
        .rst_in               (rst_in),
        .frame_start_in       (frame_start_in),
        .particle_count_in    (particle_count_in),
        .pmem_addr_out        (pmem_addr_out),
        .pmem_data_in         (pmem_data_in),
        .render_x_out         (render_x_out),
        .render_y_out         (render_y_out),
        .render_z_out         (render_z_out),
        .render_valid_out     (render_valid_out),
        .render_ready_in      (render_ready_in),
        .render_pixel_valid_in(render_pixel_valid_in),
        .render_addr_in       (render_addr_in),
        .render_color_in      (render_color_in),
        .fb_we_out            (fb_we_out),
        .fb_addr_out          (fb_addr_out),
        .fb_data_out          (fb_data_out),
        .busy_out             (busy_out),
        .frame_done_out       (frame_done_out)
    );

    always #5 clk = ~clk;

    // Particle BRAM model: word appears LAT cycles after the address is presented.
    logic [47:0] mem [256];
    logic [47:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem[pmem_addr_out[7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign pmem_data_in = pipe[LAT-1];

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit          busy_m;
    int          exp_count, exp_clr, clr_writes, xfers, dones;
    int          since_xfer, run;
    bit          stall_prev;
    logic [47:0] held_pos;

    // Stimulus controls
    bit          rnd_ready, rnd_pix, noise_start, hold_req, start_req, forced100;
    int          hold_cnt;
    logic [15:0] start_count;

    task automatic model_reset();
        busy_m     = 1'b0;
        stall_prev = 1'b0;
        since_xfer = 1000;
        run        = 0;
        hold_cnt   = 0;
    endtask

    // One clock window: drive inputs after the falling edge, then check outputs.
    task automatic step();
        bit xfer;
        @(negedge clk);
        frame_start_in    = 1'b0;
        particle_count_in = 16'($urandom);
        if (start_req) begin
            frame_start_in    = 1'b1;
            particle_count_in = start_count;
            start_req         = 1'b0;
        end else if (noise_start && busy_m && $urandom_range(0, 15) == 0) begin
            frame_start_in = 1'b1;
        end
        if (hold_req && render_valid_out && hold_cnt == 0) begin
            hold_cnt = 10;
            hold_req = 1'b0;
        end
        if (hold_cnt > 0) begin
            render_ready_in = 1'b0;
            hold_cnt--;
        end else begin
            render_ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        render_pixel_valid_in = 1'b0;
        render_addr_in        = 16'($urandom);
        render_color_in       = 16'($urandom);
        if (rnd_pix && !forced100 && busy_m && exp_clr == 100) begin
            render_pixel_valid_in = 1'b1;
            render_addr_in        = 16'd100;
            render_color_in       = 16'hF800;
            forced100             = 1'b1;
        end else if (rnd_pix && $urandom_range(0, 15) == 0) begin
            render_pixel_valid_in = 1'b1;
        end
        #1;
        xfer = render_valid_out && render_ready_in;
        chk("busy", busy_out, busy_m);
        if (render_pixel_valid_in) begin
            chk("fb_we_px", fb_we_out, 1);
            chk("fb_addr_px", fb_addr_out, render_addr_in);
            chk("fb_data_px", fb_data_out, render_color_in);
        end else if (fb_we_out) begin
            chk("clr_in_range", exp_clr < NPIX, 1);
            chk("clr_addr", fb_addr_out, exp_clr);
            chk("clr_data", fb_data_out, BG);
            exp_clr++;
            clr_writes++;
        end
        if (stall_prev) begin
            chk("hold_valid", render_valid_out, 1);
            chk("hold_xyz", {render_x_out, render_y_out, render_z_out}, held_pos);
        end
        if (since_xfer >= 1 && since_xfer <= GAPC) chk("gap_valid", render_valid_out, 0);
        if (xfer) begin
            chk("xfer_in_range", xfers < exp_count, 1);
            chk("xfer_xyz", {render_x_out, render_y_out, render_z_out}, mem[xfers & 255]);
            xfers++;
        end
        if (frame_done_out) begin
            dones++;
            chk("done_quiet_run", (run >= DRN && run <= DRN + GAPC), 1);
        end
        stall_prev = render_valid_out && !render_ready_in;
        held_pos   = {render_x_out, render_y_out, render_z_out};
        since_xfer = xfer ? 0 : ((since_xfer < 1000) ? since_xfer + 1 : since_xfer);
        run = (xfer || render_pixel_valid_in || !render_ready_in || fb_we_out) ? 0 : run + 1;
        if (frame_done_out) begin
            busy_m = 1'b0;
        end else if (!busy_m && frame_start_in) begin
            busy_m     = 1'b1;
            exp_count  = int'(particle_count_in);
            exp_clr    = 0;
            clr_writes = 0;
            xfers      = 0;
            dones      = 0;
            forced100  = 1'b0;
        end
    endtask

    task automatic run_frame(input int cnt);
        int n;
        start_req   = 1'b1;
        start_count = 16'(cnt);
        step();
        n = 0;
        while (dones == 0 && n < 20000) begin
            step();
            n++;
        end
        chk("frame_timeout", dones > 0, 1);
        for (int i = 0; i < 3; i++) step();
        chk("clr_count", clr_writes, NPIX);
        chk("xfer_count", xfers, cnt);
        chk("done_count", dones, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
        rnd_ready = 0; rnd_pix = 0; noise_start = 0; hold_req = 0;
        start_req = 0; forced100 = 0; start_count = '0;
        exp_count = 0; exp_clr = 0; clr_writes = 0; xfers = 0; dones = 0;
        held_pos = '0;
        model_reset();
        rst_in = 1'b1;
        frame_start_in = 1'b0; particle_count_in = '0;
        render_ready_in = 1'b0; render_pixel_valid_in = 1'b0;
        render_addr_in = '0; render_color_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_valid", render_valid_out, 0);
        chk("rst_pmem_addr", pmem_addr_out, 0);
        chk("rst_xyz", {render_x_out, render_y_out, render_z_out}, 0);
        chk("rst_fb_we", fb_we_out, 0);
        @(negedge clk);
        rst_in = 1'b0;
        repeat (2) step();

        // Plain frame, renderer always ready
        run_frame(3);

        // Pixel injection during clear, random ready, 10-cycle ready hold, ignored starts
        rnd_pix = 1; rnd_ready = 1; noise_start = 1; hold_req = 1;
        run_frame(4);
        rnd_pix = 0; rnd_ready = 0; noise_start = 0; hold_req = 0;

        // Empty frame
        run_frame(0);

        // Async reset while fetching the second particle
        begin
            int n;
            start_req = 1'b1;
            start_count = 16'd3;
            step();
            n = 0;
            while (!(xfers == 1 && since_xfer == GAPC) && n < 5000) begin
                step();
                n++;
            end
            chk("abort_reach_fetch", (xfers == 1 && since_xfer == GAPC), 1);
            @(negedge clk);
            frame_start_in = 1'b0;
            render_pixel_valid_in = 1'b0;
            #2 rst_in = 1'b1;
            #1;
            chk("abort_busy", busy_out, 0);
            chk("abort_done", frame_done_out, 0);
            chk("abort_valid", render_valid_out, 0);
            chk("abort_pmem_addr", pmem_addr_out, 0);
            chk("abort_xyz", {render_x_out, render_y_out, render_z_out}, 0);
            chk("abort_fb_we", fb_we_out, 0);
            @(negedge clk);
            rst_in = 1'b0;
            model_reset();
            dones = 0;
            for (int i = 0; i < 4; i++) step();
            chk("abort_no_done", dones, 0);
        end
        run_frame(1);

        // Fully randomized frames
        for (int f = 0; f < 2; f++) begin
            rnd_pix = 1; rnd_ready = 1; noise_start = 1; hold_req = ($urandom_range(0, 1) == 1);
            run_frame($urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
